// File: rtl/barrel_select_pipe.sv
// barrel_select_pipe: picks one of NCH channels, then passes, rotates or shifts it.
// Two registered stages with valid/ready flow control on both sides.
module barrel_select_pipe #(
    parameter int WIDTH = 64,
    parameter int NCH   = 10,
    parameter int SELW  = 4,
    parameter int SHW   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic [SHW-1:0]       in_shamt,
    input  logic [1:0]           in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err,
    input  logic                 err_clr
);

    typedef struct packed {
        logic [WIDTH-1:0] chan;
        logic [SHW-1:0]   shamt;
        logic [1:0]       mode;
    } s1_t;

    localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

    logic               s1_valid;
    s1_t                s1_q;
    logic               s1_en;
    logic               s2_en;
    logic               accept;
    logic               sel_ok;
    logic [WIDTH-1:0]   last_good;
    logic [WIDTH-1:0]   chan_pick;
    logic [WIDTH-1:0]   result;
    logic [2*WIDTH-1:0] rot_dbl;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = rst_n && s1_en;
    assign accept   = in_valid && in_ready;
    assign sel_ok   = {1'b0, in_sel} < NCH_L;

    // An out-of-range select falls through to the last good selection.
    always_comb begin
        chan_pick = last_good;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel == SELW'(k)) chan_pick = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Rotate as the upper half of the self-concatenation shifted left.
    assign rot_dbl = {s1_q.chan, s1_q.chan} << s1_q.shamt;

    always_comb begin
        result = s1_q.chan;
        case (s1_q.mode)
            2'b00:   result = s1_q.chan;
            2'b01:   result = rot_dbl[2*WIDTH-1 -: WIDTH];
            2'b10:   result = s1_q.chan << s1_q.shamt;
            2'b11:   result = s1_q.chan >> s1_q.shamt;
            default: result = s1_q.chan;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            last_good <= '0;
        end else begin
            if (s1_en) s1_valid <= accept;
            if (accept) begin
                s1_q.chan  <= chan_pick;
                s1_q.shamt <= in_shamt;
                s1_q.mode  <= in_mode;
                if (sel_ok) last_good <= chan_pick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= result;
        end
    end

    // A bad accept beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) sel_err <= 1'b0;
        else if (accept && !sel_ok) sel_err <= 1'b1;
        else if (err_clr) sel_err <= 1'b0;
    end

endmodule
